// File: rtl/execute_cc_stage_pkg.sv
// execute_cc_stage_pkg: shared encodings, CC layout and condition evaluation for the execute stage
package execute_cc_stage_pkg;
  localparam int ALU_W = 64;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } cond_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  // Returns {legal, outcome}; an unknown condition yields outcome 0.
  function automatic logic [1:0] cond_eval(input logic [3:0] c, input logic [2:0] f);
    logic lt;
    lt = f[CC_SF] ^ f[CC_OF];
    case (c)
      C_ALWAYS: return 2'b11;
      C_LE:     return {1'b1, lt | f[CC_ZF]};
      C_L:      return {1'b1, lt};
      C_E:      return {1'b1, f[CC_ZF]};
      C_NE:     return {1'b1, !f[CC_ZF]};
      C_GE:     return {1'b1, !lt};
      C_G:      return {1'b1, !lt && !f[CC_ZF]};
      default:  return 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/and64_datapath.sv
// and64_datapath: bitwise AND datapath; overflow is structurally zero
module and64_datapath #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  assign y   = a & b;
  assign ovf = 1'b0;
endmodule

// File: rtl/execute_cc_stage_alu_core.sv
// alu_core: combinational result, overflow and legality per ifun
module alu_core
  import execute_cc_stage_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   ifun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         of,
  output logic         legal
);
  logic [W-1:0] sum, diff, and_y;
  logic and_of;

  and64_datapath #(.W(W)) u_and (
    .a  (a),
    .b  (b),
    .y  (and_y),
    .ovf(and_of)
  );

  assign sum  = b + a;
  assign diff = b - a;

  // select the operation; illegal ifun yields zero with legal cleared
  always_comb begin
    y     = '0;
    of    = 1'b0;
    legal = 1'b1;
    case (ifun)
      ALU_ADD: begin
        y  = sum;
        of = (a[W-1] == b[W-1]) && (sum[W-1] != b[W-1]);
      end
      ALU_SUB: begin
        y  = diff;
        of = (a[W-1] != b[W-1]) && (diff[W-1] != b[W-1]);
      end
      ALU_AND: begin
        y  = and_y;
        of = and_of;
      end
      ALU_XOR: y = b ^ a;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/execute_cc_stage.sv
// execute_cc_stage: one-deep execute register with ALU, condition codes and handshake
module execute_cc_stage
  import execute_cc_stage_pkg::*;
#(
  parameter int ALU_W = execute_cc_stage_pkg::ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [ALU_W-1:0] val_a,
  input  logic [ALU_W-1:0] val_b,
  input  logic             set_cc,
  input  logic [3:0]       cond,
  input  logic             bubble,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] val_e,
  output logic             cnd,
  output logic [2:0]       cc,
  output logic             err
);
  state_e state, state_nx;
  logic [ALU_W-1:0] y;
  logic of_nx, legal_op, accept;
  logic [1:0] ce;

  alu_core #(.W(ALU_W)) u_alu (
    .ifun (ifun),
    .a    (val_a),
    .b    (val_b),
    .y    (y),
    .of   (of_nx),
    .legal(legal_op)
  );

  assign accept = in_valid && in_ready;
  // condition sees CC as it stood before this instruction's update
  assign ce = cond_eval(cond, cc);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  end

  // next state: bubble flushes, accept fills, drain empties
  always_comb begin
    state_nx = bubble ? S_IDLE : accept ? S_FULL : out_ready ? S_IDLE : state;
  end

  // handshake outputs; bubble blocks acceptance
  always_comb begin
    out_valid = state == S_FULL;
    in_ready  = !bubble && (!out_valid || out_ready);
  end

  // result register: cleared by bubble, loaded on accept, otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_e <= '0;
      cnd   <= 1'b0;
      err   <= 1'b0;
    end else if (bubble) begin
      val_e <= '0;
      cnd   <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      val_e <= y;
      cnd   <= ce[0];
      err   <= !legal_op || !ce[1];
    end
  end

  // architectural condition codes, written only by legal set_cc instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cc <= CC_RESET;
    else if (accept && set_cc && legal_op) cc <= {y == '0, y[ALU_W-1], of_nx};
  end
endmodule

// File: tb/tb_execute_cc_stage.sv
// tb_execute_cc_stage: directed self-checking bench for execute_cc_stage
module tb_execute_cc_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, set_cc, bubble, out_valid, out_ready, cnd, err;
  logic [3:0]  ifun, cond;
  logic [63:0] val_a, val_b, val_e;
  logic [2:0]  cc;
  int total = 0;
  int bad = 0;

  execute_cc_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ifun     (ifun),
    .val_a    (val_a),
    .val_b    (val_b),
    .set_cc   (set_cc),
    .cond     (cond),
    .bubble   (bubble),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .val_e    (val_e),
    .cnd      (cnd),
    .cc       (cc),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [63:0] b, input logic [63:0] a,
                       input logic s, input logic [3:0] c);
    in_valid = v;
    ifun     = f;
    val_b    = b;
    val_a    = a;
    set_cc   = s;
    cond     = c;
  endtask

  task automatic res(input string tag, input logic ov, input logic [63:0] e, input logic c,
                     input logic [2:0] f, input logic er);
    chk({tag, ".out_valid"}, out_valid, ov);
    chk({tag, ".val_e"}, val_e, e);
    chk({tag, ".cnd"}, cnd, c);
    chk({tag, ".cc"}, cc, f);
    chk({tag, ".err"}, err, er);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    repeat (2) @(negedge clk);
    res("reset", 1'b0, 64'd0, 1'b0, 3'b100, 1'b0);
    rst_n = 1'b1;
    // add into signed overflow
    drive(1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd0);
    #1 chk("idle.in_ready", in_ready, 1'b1);
    @(negedge clk);
    res("add_ovf", 1'b1, 64'h8000_0000_0000_0000, 1'b1, 3'b011, 1'b0);
    // sub to zero
    drive(1'b1, 4'd1, 64'd5, 64'd5, 1'b1, 4'd0);
    @(negedge clk);
    res("sub_zero", 1'b1, 64'd0, 1'b1, 3'b100, 1'b0);
    // cond e sees the previous ZF, no CC write
    drive(1'b1, 4'd0, 64'd2, 64'd1, 1'b0, 4'd3);
    @(negedge clk);
    res("cond_e", 1'b1, 64'd3, 1'b1, 3'b100, 1'b0);
    // and, cond g false on ZF=1
    drive(1'b1, 4'd2, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 4'd6);
    @(negedge clk);
    res("and", 1'b1, 64'h0F0F_0000_0F0F_0000, 1'b0, 3'b000, 1'b0);
    // xor, cond ne on ZF=0
    drive(1'b1, 4'd3, 64'hF0, 64'h0F, 1'b1, 4'd4);
    @(negedge clk);
    res("xor", 1'b1, 64'hFF, 1'b1, 3'b000, 1'b0);
    // stall three cycles with input pending
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 64'd1, 64'd1, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.in_ready", in_ready, 1'b0);
      @(negedge clk);
      res("stall", 1'b1, 64'hFF, 1'b1, 3'b000, 1'b0);
    end
    out_ready = 1'b1;
    #1 chk("release.in_ready", in_ready, 1'b1);
    @(negedge clk);
    res("release", 1'b1, 64'd2, 1'b1, 3'b000, 1'b0);
    // back-to-back: negative result, cond ge on old CC
    drive(1'b1, 4'd1, 64'd2, 64'd3, 1'b1, 4'd5);
    @(negedge clk);
    res("sub_neg", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b010, 1'b0);
    // illegal ifun
    drive(1'b1, 4'd7, 64'd1, 64'd1, 1'b1, 4'd0);
    @(negedge clk);
    res("bad_ifun", 1'b1, 64'd0, 1'b1, 3'b010, 1'b1);
    // illegal cond
    drive(1'b1, 4'd0, 64'd1, 64'd1, 1'b0, 4'd9);
    @(negedge clk);
    res("bad_cond", 1'b1, 64'd2, 1'b0, 3'b010, 1'b1);
    // sub overflow, cond l on SF=1 OF=0
    drive(1'b1, 4'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 4'd2);
    @(negedge clk);
    res("sub_ovf", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b001, 1'b0);
    // bubble with input pending
    bubble = 1'b1;
    drive(1'b1, 4'd0, 64'd5, 64'd5, 1'b1, 4'd0);
    #1 chk("bubble.in_ready", in_ready, 1'b0);
    @(negedge clk);
    res("bubble", 1'b0, 64'd0, 1'b0, 3'b001, 1'b0);
    bubble = 1'b0;
    // accept, cond le with SF^OF=1, then hold
    drive(1'b1, 4'd0, 64'd2, 64'd1, 1'b0, 4'd1);
    @(negedge clk);
    res("le", 1'b1, 64'd3, 1'b1, 3'b001, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    res("hold", 1'b1, 64'd3, 1'b1, 3'b001, 1'b0);
    // async reset while holding
    #2 rst_n = 1'b0;
    #1 res("async_rst", 1'b0, 64'd0, 1'b0, 3'b100, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 64'd0, 64'd0, 1'b1, 4'd3);
    @(negedge clk);
    res("post_rst", 1'b1, 64'd0, 1'b1, 3'b100, 1'b0);
    // drain without accept
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain.out_valid", out_valid, 1'b0);
    chk("drain.cc", cc, 3'b100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
